// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and helpers for the data-memory responder.
//
// Contents:
//   dmem_state_t  responder FSM states (IDLE, WAIT, RESP)
//   dmem_rsel_t   source currently driving the responder's rdata output
//   MMIO_ADDR     byte address of the memory-mapped output register
//   dmem_addr_ok  word-aligned and inside a data store of the given depth
//
// The MMIO register exists only when DMEM_MMIO_EN is defined. MMIO_ADDR is
// always declared so that both builds share one set of definitions.

package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   typedef enum logic [1:0] {
      RSEL_ZERO  = 2'd0,
      RSEL_ARRAY = 2'd1,
      RSEL_MMIO  = 2'd2
   } dmem_rsel_t;

   localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

   // The limit is computed in 34 bits so a store of 2^30 words or more
   // cannot wrap the comparison.
   function automatic logic dmem_addr_ok(input logic [31:0] addr,
                                         input int unsigned depth);
      logic [33:0] limit;
      limit = 34'(depth) << 2;
      return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word store with a synchronous write and a
// registered read.
//
// Parameters:
//   DEPTH  number of 32-bit words (power of two, at least 2)
// Ports:
//   clk    clock
//   we     write mem[idx] with wdata on this edge
//   re     load rdata with mem[idx] on this edge; rdata holds otherwise
//   idx    word index
//   wdata  write data
//   rdata  registered read data
//
// The contents and the read register are deliberately not reset.

module dmem_array #(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   // Write and registered read share the same index. The responder never
   // asserts we and re together, so read-during-write ordering never matters.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      if (re) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder behind the MEM stage.
//
// Each request is accepted in IDLE and held in WAIT for WAIT_STATES cycles.
// The responder then finishes with a one-cycle ready pulse in RESP. stall
// freezes the pipeline from acceptance until RESP.
//
// Parameters:
//   DEPTH        data store size in 32-bit words (power of two, at least 2)
//   WAIT_STATES  cycles spent in WAIT per transaction (at least 0)
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   req          request present; held by the pipeline while stall=1
//   mwr          1 = store, 0 = load
//   addr         byte address
//   wdata        store data
//   rdata        load data, valid with ready, held otherwise
//   ready        one-cycle completion pulse
//   err          completion with error (misaligned or out of range)
//   stall        (IDLE & req) | WAIT
//   mmio_out     memory-mapped output register (DMEM_MMIO_EN builds only)
//
// Build option: defining DMEM_MMIO_EN adds the mmio_out register at
// MMIO_ADDR. Without DMEM_MMIO_EN, MMIO_ADDR is simply out of range.

module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        req,
   input  logic        mwr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        stall
`ifdef DMEM_MMIO_EN
   ,
   output logic [31:0] mmio_out
`endif
);

   localparam int AW       = $clog2(DEPTH);
   localparam int CW       = ($clog2(WAIT_STATES + 1) > 1) ? $clog2(WAIT_STATES + 1) : 1;
   localparam int CNT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

   dmem_state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic        commit;

   logic        cap_mwr;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;

   logic        c_mwr;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic        c_ok;
   logic        c_mmio;
   logic        c_err;

   logic        arr_we;
   logic        arr_re;
   logic [31:0] arr_rdata;

   dmem_rsel_t  rsel;
   logic        err_q;

   // State and wait counter registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state logic. commit marks the edge that enters RESP, which is the
   // single point where a store is written or a load is registered. RESP
   // ignores req because the pipeline is still holding the old request.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      commit  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CW'(CNT_LOAD);
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_d = RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capture the request on acceptance so the commit does not depend on the
   // pipeline's inputs staying stable through WAIT.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cap_mwr   <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else if (state == IDLE && req) begin
         cap_mwr   <= mwr;
         cap_addr  <= addr;
         cap_wdata <= wdata;
      end
   end

   // With WAIT_STATES=0 the commit edge is also the capture edge, so the
   // commit operands must come straight from the inputs while in IDLE.
   assign c_mwr   = (state == IDLE) ? mwr   : cap_mwr;
   assign c_addr  = (state == IDLE) ? addr  : cap_addr;
   assign c_wdata = (state == IDLE) ? wdata : cap_wdata;

   assign c_ok = dmem_addr_ok(c_addr, DEPTH);
`ifdef DMEM_MMIO_EN
   assign c_mmio = (c_addr == MMIO_ADDR);
`else
   assign c_mmio = 1'b0;
`endif
   assign c_err = !c_ok && !c_mmio;

   assign arr_we = commit &&  c_mwr && c_ok && !c_mmio;
   assign arr_re = commit && !c_mwr && c_ok && !c_mmio;

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .re    (arr_re),
      .idx   (c_addr[2 +: AW]),
      .wdata (c_wdata),
      .rdata (arr_rdata)
   );

   // Completion status and the rdata source select. Only loads move rsel,
   // so a store leaves rdata exactly as the last load left it.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         err_q <= 1'b0;
         rsel  <= RSEL_ZERO;
      end else if (commit) begin
         err_q <= c_err;
         if (!c_mwr) begin
            if (c_err) begin
               rsel <= RSEL_ZERO;
            end else if (c_mmio) begin
               rsel <= RSEL_MMIO;
            end else begin
               rsel <= RSEL_ARRAY;
            end
         end
      end
   end

`ifdef DMEM_MMIO_EN
   logic [31:0] mmio_q;
   logic [31:0] mmio_rd_q;

   // MMIO loads snapshot the register. A later MMIO store then cannot
   // change the rdata that the earlier load returned.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mmio_q    <= '0;
         mmio_rd_q <= '0;
      end else if (commit && c_mmio) begin
         if (c_mwr) begin
            mmio_q <= c_wdata;
         end else begin
            mmio_rd_q <= mmio_q;
         end
      end
   end

   assign mmio_out = mmio_q;
`endif

   // rdata mux. RSEL_ZERO covers reset and error loads.
   always_comb begin
      rdata = '0;
      case (rsel)
         RSEL_ARRAY: rdata = arr_rdata;
`ifdef DMEM_MMIO_EN
         RSEL_MMIO:  rdata = mmio_rd_q;
`endif
         default:    rdata = '0;
      endcase
   end

   assign ready = (state == RESP);
   assign err   = (state == RESP) && err_q;
   assign stall = ((state == IDLE) && req) || (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder.
//
// Two instances share clk and n_rst:
//   dut   DEPTH=256, WAIT_STATES=2
//   dut0  DEPTH=16,  WAIT_STATES=0, driven back to back
// Expected values are hand-computed constants. mmio_out is connected and
// checked only when DMEM_MMIO_EN is defined.

module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        n_rst;

   logic        req, mwr;
   logic [31:0] addr, wdata, rdata;
   logic        ready, err, stall;

   logic        req0, mwr0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        ready0, err0, stall0;

`ifdef DMEM_MMIO_EN
   logic [31:0] mmio_out;
   logic [31:0] mmio_out0;
`endif

   int checks = 0;
   int errors = 0;

   // Table for the back-to-back WAIT_STATES=0 sequence.
   logic        t_mwr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic [31:0] t_addr [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
   logic [31:0] t_data [4] = '{32'h11, 32'h22, 32'h0, 32'h0};
   logic [31:0] t_exp  [4] = '{32'h0, 32'h0, 32'h11, 32'h22};

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH       (256),
      .WAIT_STATES (2)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .req      (req),
      .mwr      (mwr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .err      (err),
      .stall    (stall)
`ifdef DMEM_MMIO_EN
      ,
      .mmio_out (mmio_out)
`endif
   );

   dmem_responder #(
      .DEPTH       (16),
      .WAIT_STATES (0)
   ) dut0 (
      .clk      (clk),
      .n_rst    (n_rst),
      .req      (req0),
      .mwr      (mwr0),
      .addr     (addr0),
      .wdata    (wdata0),
      .rdata    (rdata0),
      .ready    (ready0),
      .err      (err0),
      .stall    (stall0)
`ifdef DMEM_MMIO_EN
      ,
      .mmio_out (mmio_out0)
`endif
   );

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive the request inputs of one instance (0 = dut, 1 = dut0).
   task automatic applyStimulus(input int unit, input logic r, input logic m,
                                input logic [31:0] a, input logic [31:0] d);
      if (unit == 0) begin
         req = r; mwr = m; addr = a; wdata = d;
      end else begin
         req0 = r; mwr0 = m; addr0 = a; wdata0 = d;
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full WAIT_STATES=2 transaction on dut: acceptance cycle N, WAIT in
   // N+1..N+2, RESP in N+3, then one idle cycle that checks rdata holds.
   task automatic runTxn(input string tag, input logic m, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input logic exp_err);
      tick();
      applyStimulus(0, 1'b1, m, a, d);
      #1;
      checkOutput({tag, ".accept_stall"}, 32'(stall), 32'd1);
      checkOutput({tag, ".accept_ready"}, 32'(ready), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput({tag, ".wait_stall"}, 32'(stall), 32'd1);
         checkOutput({tag, ".wait_ready"}, 32'(ready), 32'd0);
      end
      tick();
      checkOutput({tag, ".resp_ready"}, 32'(ready), 32'd1);
      checkOutput({tag, ".resp_stall"}, 32'(stall), 32'd0);
      checkOutput({tag, ".resp_err"},   32'(err),   32'(exp_err));
      checkOutput({tag, ".resp_rdata"}, rdata, exp_rd);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput({tag, ".idle_ready"}, 32'(ready), 32'd0);
      checkOutput({tag, ".idle_stall"}, 32'(stall), 32'd0);
      checkOutput({tag, ".idle_rdata_hold"}, rdata, exp_rd);
   endtask

   // Guard against a hang; reports as a failure before stopping.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      n_rst = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("rst.rdata",  rdata,        32'h0);
      checkOutput("rst.ready",  32'(ready),   32'd0);
      checkOutput("rst.err",    32'(err),     32'd0);
      checkOutput("rst.stall",  32'(stall),   32'd0);
      checkOutput("rst.ready0", 32'(ready0),  32'd0);
      checkOutput("rst.rdata0", rdata0,       32'h0);
`ifdef DMEM_MMIO_EN
      checkOutput("rst.mmio",   mmio_out,     32'h0);
`endif
      applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("rst.stall_req", 32'(stall), 32'd1);
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      $display("[TB] reset released");

      // WAIT_STATES=0 back to back: accepted every second cycle.
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1'b1, t_mwr[i], t_addr[i], t_data[i]);
         #1;
         checkOutput($sformatf("ws0[%0d].accept_stall", i), 32'(stall0), 32'd1);
         checkOutput($sformatf("ws0[%0d].accept_ready", i), 32'(ready0), 32'd0);
         tick();
         checkOutput($sformatf("ws0[%0d].resp_ready", i), 32'(ready0), 32'd1);
         checkOutput($sformatf("ws0[%0d].resp_stall", i), 32'(stall0), 32'd0);
         checkOutput($sformatf("ws0[%0d].resp_err", i),   32'(err0),   32'd0);
         checkOutput($sformatf("ws0[%0d].resp_rdata", i), rdata0,      t_exp[i]);
         tick();
      end
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("ws0.idle_stall", 32'(stall0), 32'd0);

      // Basic store/load on the WAIT_STATES=2 instance.
      runTxn("st10",  1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
      runTxn("ld10",  1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      runTxn("st3fc", 1'b1, 32'h3FC, 32'h55AA55AA, 32'hDEADBEEF, 1'b0);
      runTxn("ld3fc", 1'b0, 32'h3FC, 32'h0,        32'h55AA55AA, 1'b0);

      // Error cases: misaligned, first out-of-range word, misaligned store.
      runTxn("ld13",  1'b0, 32'h13,  32'h0,        32'h0,        1'b1);
      runTxn("ld400", 1'b0, 32'h400, 32'h0,        32'h0,        1'b1);
      runTxn("st13",  1'b1, 32'h13,  32'h00000BAD, 32'h0,        1'b1);
      runTxn("ld10b", 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);

      // Reset in the middle of a store's WAIT must abort it.
      runTxn("st20",  1'b1, 32'h20,  32'h00C0FFEE, 32'hDEADBEEF, 1'b0);
      tick();
      applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h00001234);
      #1;
      checkOutput("abort.accept_stall", 32'(stall), 32'd1);
      tick();
      checkOutput("abort.wait_stall", 32'(stall), 32'd1);
      n_rst = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("abort.stall", 32'(stall), 32'd0);
      checkOutput("abort.ready", 32'(ready), 32'd0);
      checkOutput("abort.err",   32'(err),   32'd0);
      checkOutput("abort.rdata", rdata,      32'h0);
      tick();
      tick();
      n_rst = 1'b1;
      runTxn("ld20",  1'b0, 32'h20,  32'h0,        32'h00C0FFEE, 1'b0);

      // MMIO address.
`ifdef DMEM_MMIO_EN
      runTxn("stmmio", 1'b1, 32'hFFFF_FFF0, 32'hA5, 32'h00C0FFEE, 1'b0);
      checkOutput("stmmio.mmio_out", mmio_out, 32'hA5);
      runTxn("ldmmio", 1'b0, 32'hFFFF_FFF0, 32'h0,  32'hA5,       1'b0);
`else
      runTxn("stmmio", 1'b1, 32'hFFFF_FFF0, 32'hA5, 32'h00C0FFEE, 1'b1);
      runTxn("ldmmio", 1'b0, 32'hFFFF_FFF0, 32'h0,  32'h0,        1'b1);
`endif

      // req held high through RESP with different data: RESP must not
      // commit again and the FSM must be back in IDLE afterwards.
      tick();
      applyStimulus(0, 1'b1, 1'b1, 32'h30, 32'h00001111);
      tick();
      tick();
      tick();
      checkOutput("hold.resp_ready", 32'(ready), 32'd1);
      applyStimulus(0, 1'b1, 1'b1, 32'h30, 32'h00002222);
      #1;
      checkOutput("hold.resp_stall", 32'(stall), 32'd0);
      checkOutput("hold.resp_ready2", 32'(ready), 32'd1);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("hold.idle_stall", 32'(stall), 32'd0);
      checkOutput("hold.idle_ready", 32'(ready), 32'd0);
      runTxn("ld30",  1'b0, 32'h30,  32'h0,        32'h00001111, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
